clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//   NCH independent programmable clock dividers sharing one input clock. Each
//   channel produces a registered divided clock (period = DIV input cycles,
//   high for ceil(DIV/2)). Divisors are reprogrammed at runtime through a
//   valid/ready port and take effect glitch-free at the channel's next period
//   boundary. Sits between the board oscillator and GPIO/peripheral timing.
// PARAMETERS
//   NCH      4    number of divider channels (1..16)
//   CNT_W    10   counter/divisor width; max divisor 2**CNT_W-1
//   DEF_DIV  2    divisor loaded into every channel at reset (0 = stopped)
// PORTS
//   clk        in   1            input clock, all logic on posedge
//   rst        in   1            asynchronous reset, active-high
//   sync       in   1            1-cycle pulse: restart all channels in phase
//   cfg_valid  in   1            divisor write request
//   cfg_ready  out  1            write accepted when cfg_valid & cfg_ready
//   cfg_ch     in   $clog2(NCH)  target channel
//   cfg_div    in   CNT_W        new divisor
//   div_out    out  NCH          divided clocks, bit i = channel i
//   tick       out  NCH          (CLK_DIV_TICK_EN only) wrap pulse per channel
// BEHAVIOUR
//   - Reset (async, rst=1): cnt=0, active div=DEF_DIV, pending=0, div_out=0,
//     tick=0. Outputs are registers, no combinational path to div_out.
//   - Per channel, active div D>=2, each posedge: div_out <= (cnt < ceil(D/2));
//     cnt <= (cnt==D-1) ? 0 : cnt+1. div_out lags cnt by one cycle; first high
//     on the first edge after rst deasserts.
//   - D==0: channel stopped, cnt held 0, div_out <= 0. D==1 clamped to 2.
//   - cfg_ready = ~pending[cfg_ch]. On handshake: shadow[cfg_ch] <= cfg_div,
//     pending[cfg_ch] <= 1. cfg_ch >= NCH: write accepted and discarded.
//   - Pending applied (active<=shadow, cnt<=0, pending<=0) on the boundary
//     edge: cnt==D-1, or any edge when D==0, or sync. New value governs
//     div_out from the following edge; no runt high/low pulse.
//   - sync: every channel cnt<=0 and applies its pending value that edge;
//     div_out <= 0 that edge, period restarts next edge. sync overrides wrap.
//   - Handshake on same edge as boundary for same channel: pending set, value
//     applied at the NEXT boundary (apply uses old shadow first).
//   - Width: cnt compare unsigned CNT_W bits; ceil(D/2) = (D+1)>>1, CNT_W bits.
//   - rst mid-period: immediate return to reset state; pending writes lost.
// CONFIGURATION
//   CLK_DIV_TICK_EN defined: port tick[NCH-1:0] exists; tick[i]=1 for the one
//     cycle after the edge where channel i wrapped (cnt==D-1, D>=2); 0 on
//     sync edge and when stopped. Undefined: port and logic absent, all else
//     identical.
// STRUCTURE
//   - clk_div_pkg: CNT_W default, DIV_STOP=0, DIV_MIN=2, half_hi() function.
//   - Sub-module clk_div_chan (one channel: cnt, active, shadow, pending,
//     div_out, tick), instantiated NCH times via generate; top holds cfg
//     decode and cfg_ready mux.
// TESTING
//   1. Reset, DEF_DIV=2 -> div_out[0] = 0,1,0,1... toggling every cycle from
//      first edge after rst falls.
//   2. Write ch1 div=5 -> after boundary, high 3 / low 2 cycles, period 5;
//      cfg_ready low for ch1 until applied, high for other channels.
//   3. Write ch2 div=0 then div=4 -> ch2 out held 0, then 4-cycle period
//      starts the edge after second apply.
//   4. Channels at div 3 and 4, pulse sync -> both div_out 0 on sync edge,
//      rise together next edge; pending write applied on sync edge.
//   5. Assert rst mid-period with pending write -> outputs 0 at once; after
//      release period = DEF_DIV, pending value not applied.
//   6. CLK_DIV_TICK_EN, div=4 -> tick high 1 cycle in every 4; absent when
//      macro undefined (compile check).

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional per-channel wrap pulse output: define CLK_DIV_TICK_EN.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF = 10;
    localparam int unsigned DIV_STOP  = 0;
    localparam int unsigned DIV_MIN   = 2;

    // Number of high cycles in one period of divisor d.
    function automatic int unsigned half_hi(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Divisor programming port: valid/ready write of one channel's divisor.
// Optional per-channel wrap pulse output: define CLK_DIV_TICK_EN.
interface clk_div_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 10
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, registered outputs.
// Optional per-channel wrap pulse output: define CLK_DIV_TICK_EN.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pending,
`ifdef CLK_DIV_TICK_EN
    output logic             tick,
`endif
    output logic             div_out
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] d_eff;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] last;
    logic             stopped;
    logic             wrap;
    logic             boundary;

    // Effective divisor (1 behaves as 2) and period boundary detection.
    always_comb begin
        d_eff    = (active == CNT_W'(1)) ? CNT_W'(DIV_MIN) : active;
        half     = CNT_W'(half_hi(32'(d_eff)));
        last     = d_eff - CNT_W'(1);
        stopped  = (active == CNT_W'(DIV_STOP));
        wrap     = ~stopped & (cnt == last);
        boundary = sync | stopped | wrap;
    end

    // Counter, divided clock and divisor swap at the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            active  <= CNT_W'(DEF_DIV);
            shadow  <= '0;
            pending <= 1'b0;
            div_out <= 1'b0;
        end else begin
            if (sync | stopped) begin
                cnt     <= '0;
                div_out <= 1'b0;
            end else begin
                div_out <= (cnt < half);
                cnt     <= wrap ? '0 : cnt + CNT_W'(1);
            end
            if (boundary && pending) begin
                active <= shadow;
            end
            pending <= wr | (pending & ~boundary);
            if (wr) begin
                shadow <= wr_div;
            end
        end
    end

`ifdef CLK_DIV_TICK_EN
    // One-cycle pulse after each natural wrap of a running channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap & ~sync;
        end
    end
`endif

endmodule

// File: rtl/clk_div_multi.sv
// NCH programmable clock dividers sharing one input clock.
// Optional per-channel wrap pulse output: define CLK_DIV_TICK_EN.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sync,
    clk_div_if.slave       cfg,
`ifdef CLK_DIV_TICK_EN
    output logic [NCH-1:0] tick,
`endif
    output logic [NCH-1:0] div_out
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NSLOT = 1 << CH_W;

    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   wr;
    logic [NSLOT-1:0] busy;
    logic             ready;

    // Unused channel slots never block, so writes to them are dropped.
    always_comb begin
        busy            = '0;
        busy[NCH-1:0]   = pending;
        ready           = ~busy[cfg.cfg_ch];
    end

    assign cfg.cfg_ready = ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr[i] = cfg.cfg_valid & ready
                     & (cfg.cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .sync    (sync),
            .wr      (wr[i]),
            .wr_div  (cfg.cfg_div),
            .pending (pending[i]),
`ifdef CLK_DIV_TICK_EN
            .tick    (tick[i]),
`endif
            .div_out (div_out[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi against a phase-arithmetic model.
// Tick checks are included when CLK_DIV_TICK_EN is defined.
module tb_clk_div_multi;

    localparam int NCH     = 4;
    localparam int CNT_W   = 10;
    localparam int DEF_DIV = 2;
    localparam int CH_W    = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           sync;
    logic [NCH-1:0] div_out;
`ifdef CLK_DIV_TICK_EN
    logic [NCH-1:0] tick;
`endif

    clk_div_if #(.NCH(NCH), .CNT_W(CNT_W)) cfg ();

    clk_div_multi #(
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sync    (sync),
        .cfg     (cfg.slave),
`ifdef CLK_DIV_TICK_EN
        .tick    (tick),
`endif
        .div_out (div_out)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: divisor, shadow, pending flag and edge number where phase 0 began.
    int             m_d    [NCH];
    int             m_sh   [NCH];
    int             m_s    [NCH];
    bit             m_pend [NCH];
    logic [NCH-1:0] exp_out;
    logic [NCH-1:0] exp_tick;
    int             e;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int deff(input int d);
        return (d == 1) ? 2 : d;
    endfunction

    function automatic logic exp_ready(input int ch);
        return (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_d[c]    = DEF_DIV;
            m_sh[c]   = 0;
            m_pend[c] = 1'b0;
            m_s[c]    = 1;
        end
        exp_out  = '0;
        exp_tick = '0;
        e        = 0;
    endtask

    task automatic model_edge(input bit sy, input bit hs,
                              input int ch, input int dv);
        int d;
        int ph;
        e++;
        for (int c = 0; c < NCH; c++) begin
            d = deff(m_d[c]);
            if (sy || m_d[c] == 0) begin
                exp_out[c]  = 1'b0;
                exp_tick[c] = 1'b0;
                if (m_pend[c]) begin
                    m_d[c]    = m_sh[c];
                    m_pend[c] = 1'b0;
                end
                m_s[c] = e + 1;
            end else begin
                ph          = (e - m_s[c]) % d;
                exp_out[c]  = (ph < (d + 1) / 2);
                exp_tick[c] = (ph == d - 1);
                if (ph == d - 1) begin
                    m_s[c] = e + 1;
                    if (m_pend[c]) begin
                        m_d[c]    = m_sh[c];
                        m_pend[c] = 1'b0;
                    end
                end
            end
        end
        if (hs && ch < NCH) begin
            m_sh[ch]   = dv;
            m_pend[ch] = 1'b1;
        end
    endtask

    task automatic cycle(input bit sy, input bit v,
                         input int ch, input int dv);
        bit hs;
        sync          = sy;
        cfg.cfg_valid = v;
        cfg.cfg_ch    = ch[CH_W-1:0];
        cfg.cfg_div   = dv[CNT_W-1:0];
        #1;
        check("cfg_ready", 32'(cfg.cfg_ready), 32'(exp_ready(ch)));
        hs = v && exp_ready(ch);
        @(posedge clk);
        model_edge(sy, hs, ch, dv);
        #1;
        check("div_out", 32'(div_out), 32'(exp_out));
`ifdef CLK_DIV_TICK_EN
        check("tick", 32'(tick), 32'(exp_tick));
`endif
    endtask

    task automatic idle(input int n, input int ch);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, ch, 0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        sync          = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_ch    = '0;
        cfg.cfg_div   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_div_out", 32'(div_out), 32'h0);
        check("reset_ready", 32'(cfg.cfg_ready), 32'h1);
`ifdef CLK_DIV_TICK_EN
        check("reset_tick", 32'(tick), 32'h0);
`endif
        rst = 1'b0;

        // Default divisor 2: every channel toggles from the first edge.
        cycle(1'b0, 1'b0, 0, 0);
        check("first_high", 32'(div_out), 32'hF);
        cycle(1'b0, 1'b0, 0, 0);
        check("first_low", 32'(div_out), 32'h0);
        idle(4, 0);

        // Channel 1 to divisor 5; ready for ch1 stays low until applied.
        cycle(1'b0, 1'b1, 1, 5);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b0, (i % 3 == 0) ? 0 : 1, 0);
        end

        // Channel 2 stopped, then restarted at divisor 4.
        cycle(1'b0, 1'b1, 2, 0);
        idle(5, 2);
        check("ch2_stopped", 32'(div_out[2]), 32'h0);
        cycle(1'b0, 1'b1, 2, 4);
        idle(10, 2);

        // Channels at 3 and 4, pending write on ch2, then sync.
        cycle(1'b0, 1'b1, 0, 3);
        cycle(1'b0, 1'b1, 3, 4);
        idle(7, 0);
        cycle(1'b0, 1'b1, 2, 7);
        cycle(1'b1, 1'b0, 2, 0);
        check("sync_zero", 32'(div_out), 32'h0);
        cycle(1'b0, 1'b0, 2, 0);
        check("sync_rise", 32'(div_out), 32'hF);
        idle(12, 2);

        // Reset mid-period with a write still pending.
        cycle(1'b0, 1'b1, 1, 9);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out", 32'(div_out), 32'h0);
        check("rst_mid_ready", 32'(cfg.cfg_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(8, 1);

        // Randomized writes, syncs and idle cycles.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, NCH - 1)),
                  int'($urandom_range(0, 9)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
